enemy_spawn_sched: RTL and testbench
====================================

ENEMY_SPAWN_SCHED -- requirements
Module: enemy_spawn_sched

Interface
- REQ-001: Parameter NSLOT, default 4, number of enemy slots managed.
- REQ-002: Parameter NSPAWN, default 8, number of spawn-table entries per level.
- REQ-003: Parameter FIRE_GAP, default 30, minimum frames between any two fire grants.
- REQ-004: The block SHALL use one clock and an asynchronous, active-high reset, with the ports listed below.
- REQ-005: frame_clk  in  1  frame clock; all state advances on its rising edge.
- REQ-006: Reset  in  1  asynchronous active-high reset.
- REQ-007: play  in  1  high = game running; low = freeze.
- REQ-008: progress  in  12  world scroll offset.
- REQ-009: kill  in  NSLOT  per-slot enemy-hit pulses.
- REQ-010: offscreen  in  NSLOT  per-slot left-edge exit flags.
- REQ-011: fire_req  in  NSLOT  per-slot fire requests.
- REQ-012: slot_active  out  NSLOT  slot occupied.
- REQ-013: spawn_valid  out  1  one-frame spawn pulse.
- REQ-014: spawn_slot  out  2  slot receiving the spawn.
- REQ-015: spawn_x  out  13  screen X, computed as table X minus progress.
- REQ-016: spawn_y  out  10  table Y.
- REQ-017: fire_gnt  out  NSLOT  one-hot or zero fire grant.
- REQ-018: kill_count  out  8  number of kills, saturating.
- REQ-019: level_clear  out  1  all spawns done and all slots empty.

Function
- REQ-020: FSM states SHALL be IDLE, RUN and CLEAR; IDLE->RUN on first frame with play=1; RUN->CLEAR when next_idx==NSPAWN and slot_active==0; CLEAR is held until Reset.
- REQ-021: While play=0, all registers SHALL hold and spawn_valid and fire_gnt SHALL be 0.
- REQ-022: In RUN, a spawn SHALL trigger when next_idx<NSPAWN and progress+640 >= table_x[next_idx], with the comparison computed in 13 bits.
- REQ-023: On trigger, the lowest-index free slot (per registered slot_active) SHALL be allocated, next_idx incremented, and spawn_valid/slot/x/y registered, appearing the frame after trigger.
- REQ-024: At most one spawn SHALL occur per frame; if no slot is free, next_idx SHALL hold (stall) and the spawn retries every frame.
- REQ-025: A slot SHALL be released the frame after kill[i] or offscreen[i] is seen while it is active; kill/offscreen on an inactive slot SHALL be ignored.
- REQ-026: A slot released in frame N SHALL NOT be reallocated before frame N+1.
- REQ-027: kill_count SHALL increment by the number of accepted kill bits in a frame and saturate at 255; offscreen releases SHALL NOT count as kills.
- REQ-028: If kill[i] and offscreen[i] are both set in one frame, the event SHALL count as a kill.
- REQ-029: level_clear SHALL equal (state==CLEAR).

Reset
- REQ-030: On Reset: state=IDLE, next_idx=0, slot_active=0, spawn_valid=0, spawn_slot=0, spawn_x=0, spawn_y=0, fire_gnt=0, kill_count=0, level_clear=0, cooldown=0, rr_ptr=0.
- REQ-031: Reset asserted mid-level SHALL abort the level immediately and asynchronously.

Configuration
- REQ-032: With SPAWN_FIRE_ARB_EN defined, fire SHALL be arbitrated round-robin: a grant is issued only when cooldown==0, to the first requesting active slot at or after rr_ptr; on a grant, rr_ptr=granted+1 (mod NSLOT) and cooldown=FIRE_GAP-1, then cooldown decrements once per play frame.
- REQ-033: Without SPAWN_FIRE_ARB_EN, fire_gnt SHALL be registered fire_req & slot_active with no cooldown, and rr_ptr/cooldown SHALL be absent.

Structure
- REQ-034: Package enemy_pkg SHALL hold the NSPAWN-entry spawn tables (X: 800, 1584, 2352, 3790, 4400, 5100, 5800, 6500; Y: 159, 351, 255, 255, 159, 255, 351, 159), the 640 screen-width constant and the FSM state enum.
- REQ-035: The round-robin arbiter SHALL be the sub-module fire_rr_arb.

Verification
- REQ-036: Reset, then play=1 and progress=160 -> spawn_valid in the next frame with slot 0, spawn_x=640, spawn_y=159; slot_active=0001.
- REQ-037: Fill all 4 slots, advance progress past entry 4 -> no spawn and next_idx stays 4; pulse kill[2] -> slot 2 released next frame, spawned one frame later.
- REQ-038: Assert kill[1] and offscreen[1] together on an active slot 1 -> kill_count +1; kill on an inactive slot 3 -> kill_count unchanged.
- REQ-039: Hold fire_req=1111 with 4 active slots (SPAWN_FIRE_ARB_EN defined) -> grants 0001, 0010, 0100, 1000 spaced exactly 30 frames apart.
- REQ-040: Drop play mid-cooldown for 10 frames -> cooldown and outputs freeze; grant timing resumes unchanged afterward.
- REQ-041: After all 8 spawns, kill each enemy -> level_clear=1 the frame after the last release; assert Reset -> level_clear=0 immediately.

Source files
------------

// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy spawn scheduler.
//   - SCREEN_W    : visible screen width; an entry spawns once it is within one screen of the view.
//   - sched_state_e : level sequencing states.
//   - spawn_x_at / spawn_y_at : per-level spawn table (world X, screen Y), 8 entries.
package enemy_pkg;

  localparam logic [12:0] SCREEN_W = 13'd640;
  localparam int unsigned TABLE_LEN = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StClear
  } sched_state_e;

  // Out-of-range indices return 0 so a fully consumed table never reads past its end.
  function automatic logic [12:0] spawn_x_at(input int unsigned idx);
    case (idx)
      0:       return 13'd800;
      1:       return 13'd1584;
      2:       return 13'd2352;
      3:       return 13'd3790;
      4:       return 13'd4400;
      5:       return 13'd5100;
      6:       return 13'd5800;
      7:       return 13'd6500;
      default: return 13'd0;
    endcase
  endfunction

  function automatic logic [9:0] spawn_y_at(input int unsigned idx);
    case (idx)
      0:       return 10'd159;
      1:       return 10'd351;
      2:       return 10'd255;
      3:       return 10'd255;
      4:       return 10'd159;
      5:       return 10'd255;
      6:       return 10'd351;
      7:       return 10'd159;
      default: return 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/fire_rr_arb.sv
// Fire-request arbiter for the enemy slots.
// Build option: SPAWN_FIRE_ARB_EN
//   defined   : round-robin grant with a FIRE_GAP-frame cooldown between any two grants.
//   undefined : grant is simply the registered request vector, no cooldown or pointer.
// Ports:
//   frame_clk : frame clock
//   Reset     : asynchronous active-high reset
//   play      : high = running; low = hold all state, grant forced to 0
//   req       : per-slot fire requests, already qualified by slot occupancy
//   gnt       : registered grant, one-hot or zero when arbitrated
module fire_rr_arb #(
  parameter int unsigned NSLOT    = 4,
  parameter int unsigned FIRE_GAP = 30
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic             play,
  input  logic [NSLOT-1:0] req,
  output logic [NSLOT-1:0] gnt
);

  logic [NSLOT-1:0] gnt_q, gnt_d;

`ifdef SPAWN_FIRE_ARB_EN
  localparam int unsigned PW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int unsigned CW = $clog2(FIRE_GAP + 1);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cooldown_q, cooldown_d;
  logic [PW-1:0] idx;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    cooldown_d = cooldown_q;
    gnt_d      = '0;
    idx        = '0;
    if (play) begin
      if (cooldown_q == '0) begin
        // Scan from farthest to nearest so the first requester at/after rr_ptr wins.
        for (int k = NSLOT - 1; k >= 0; k--) begin
          idx = PW'((32'(rr_ptr_q) + 32'(k)) % NSLOT);
          if (req[idx]) begin
            gnt_d    = NSLOT'(1) << idx;
            rr_ptr_d = PW'((32'(idx) + 1) % NSLOT);
          end
        end
      end
      if (gnt_d != '0) begin
        cooldown_d = CW'(FIRE_GAP - 1);
      end else if (cooldown_q != '0) begin
        cooldown_d = cooldown_q - CW'(1);
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      rr_ptr_q   <= '0;
      cooldown_q <= '0;
      gnt_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      cooldown_q <= cooldown_d;
      gnt_q      <= gnt_d;
    end
  end
`else
  always_comb begin
    gnt_d = play ? req : '0;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      gnt_q <= '0;
    end else begin
      gnt_q <= gnt_d;
    end
  end
`endif

  assign gnt = gnt_q;

endmodule

// File: rtl/enemy_spawn_sched.sv
// Enemy spawn scheduler: walks the level spawn table as the world scrolls, allocates enemy
// slots, tracks releases (kill / offscreen), counts kills and arbitrates enemy fire.
// Build option: SPAWN_FIRE_ARB_EN (round-robin fire arbitration with cooldown, see fire_rr_arb).
// Ports:
//   frame_clk   : frame clock, all state advances on its rising edge
//   Reset       : asynchronous active-high reset, aborts the level
//   play        : high = running; low = freeze (spawn_valid / fire_gnt forced low)
//   progress    : world scroll offset
//   kill        : per-slot enemy-hit pulses
//   offscreen   : per-slot left-edge exit flags
//   fire_req    : per-slot fire requests
//   slot_active : slot occupancy
//   spawn_valid : one-frame spawn pulse, with spawn_slot / spawn_x / spawn_y
//   fire_gnt    : fire grant
//   kill_count  : saturating kill counter
//   level_clear : all spawns done and every slot empty
module enemy_spawn_sched
  import enemy_pkg::*;
#(
  parameter int unsigned NSLOT    = 4,
  parameter int unsigned NSPAWN   = 8,
  parameter int unsigned FIRE_GAP = 30
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic             play,
  input  logic [11:0]      progress,
  input  logic [NSLOT-1:0] kill,
  input  logic [NSLOT-1:0] offscreen,
  input  logic [NSLOT-1:0] fire_req,
  output logic [NSLOT-1:0] slot_active,
  output logic             spawn_valid,
  output logic [1:0]       spawn_slot,
  output logic [12:0]      spawn_x,
  output logic [9:0]       spawn_y,
  output logic [NSLOT-1:0] fire_gnt,
  output logic [7:0]       kill_count,
  output logic             level_clear
);

  localparam int unsigned IW = $clog2(NSPAWN + 1);

  sched_state_e     state_q, state_d;
  logic [IW-1:0]    next_idx_q, next_idx_d;
  logic [NSLOT-1:0] slot_active_q, slot_active_d;
  logic             spawn_valid_q, spawn_valid_d;
  logic [1:0]       spawn_slot_q, spawn_slot_d;
  logic [12:0]      spawn_x_q, spawn_x_d;
  logic [9:0]       spawn_y_q, spawn_y_d;
  logic [7:0]       kill_count_q, kill_count_d;

  logic [NSLOT-1:0] release_m, kill_acc, alloc_m;
  logic             free_found, trigger, spawn_ok;
  logic [1:0]       free_slot;
  logic [12:0]      tbl_x;
  logic [8:0]       kill_sum;
  logic [NSLOT-1:0] gnt_raw;

  always_comb begin
    // Allocation looks only at registered occupancy, so a slot freed this frame stays
    // unavailable until the following frame.
    release_m  = slot_active_q & (kill | offscreen);
    kill_acc   = slot_active_q & kill;
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!slot_active_q[i]) begin
        free_found = 1'b1;
        free_slot  = 2'(i);
      end
    end

    tbl_x = spawn_x_at(32'(next_idx_q));
    // The first play frame (IDLE->RUN) already behaves as RUN so the first spawn lands the
    // frame after play rises.
    trigger  = ((state_q == StRun) || (state_q == StIdle)) &&
               (next_idx_q < IW'(NSPAWN)) &&
               (({1'b0, progress} + SCREEN_W) >= tbl_x);
    spawn_ok = trigger && free_found;
    alloc_m  = spawn_ok ? (NSLOT'(1) << free_slot) : '0;

    kill_sum = {1'b0, kill_count_q};
    for (int i = 0; i < NSLOT; i++) begin
      kill_sum = kill_sum + 9'(kill_acc[i]);
    end

    state_d       = state_q;
    next_idx_d    = next_idx_q;
    slot_active_d = slot_active_q;
    spawn_valid_d = 1'b0;
    spawn_slot_d  = spawn_slot_q;
    spawn_x_d     = spawn_x_q;
    spawn_y_d     = spawn_y_q;
    kill_count_d  = kill_count_q;

    if (play) begin
      slot_active_d = (slot_active_q & ~release_m) | alloc_m;
      kill_count_d  = (kill_sum > 9'd255) ? 8'd255 : kill_sum[7:0];
      spawn_valid_d = spawn_ok;
      if (spawn_ok) begin
        next_idx_d   = next_idx_q + IW'(1);
        spawn_slot_d = free_slot;
        spawn_x_d    = tbl_x - {1'b0, progress};
        spawn_y_d    = spawn_y_at(32'(next_idx_q));
      end
      case (state_q)
        StIdle:  state_d = StRun;
        StRun: begin
          if ((next_idx_q == IW'(NSPAWN)) && (slot_active_q == '0)) state_d = StClear;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= StIdle;
      next_idx_q    <= '0;
      slot_active_q <= '0;
      spawn_valid_q <= 1'b0;
      spawn_slot_q  <= '0;
      spawn_x_q     <= '0;
      spawn_y_q     <= '0;
      kill_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      next_idx_q    <= next_idx_d;
      slot_active_q <= slot_active_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_slot_q  <= spawn_slot_d;
      spawn_x_q     <= spawn_x_d;
      spawn_y_q     <= spawn_y_d;
      kill_count_q  <= kill_count_d;
    end
  end

  fire_rr_arb #(
    .NSLOT   (NSLOT),
    .FIRE_GAP(FIRE_GAP)
  ) u_fire_arb (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .play     (play),
    .req      (fire_req & slot_active_q),
    .gnt      (gnt_raw)
  );

  // Pulse outputs drop as soon as play falls, without waiting for the next frame edge.
  assign spawn_valid = spawn_valid_q & play;
  assign fire_gnt    = gnt_raw & {NSLOT{play}};
  assign slot_active = slot_active_q;
  assign spawn_slot  = spawn_slot_q;
  assign spawn_x     = spawn_x_q;
  assign spawn_y     = spawn_y_q;
  assign kill_count  = kill_count_q;
  assign level_clear = (state_q == StClear);

endmodule

// File: tb/tb_enemy_spawn_sched.sv
// Directed bench for enemy_spawn_sched. NSPAWN is set to 5: with a 12-bit progress the view
// edge reaches at most 4095+640 = 4735, so table entries beyond X=4400 can never spawn and a
// level using them could never clear.
module tb_enemy_spawn_sched;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        play;
  logic [11:0] progress;
  logic [3:0]  kill, offscreen, fire_req;
  logic [3:0]  slot_active, fire_gnt;
  logic        spawn_valid, level_clear;
  logic [1:0]  spawn_slot;
  logic [12:0] spawn_x;
  logic [9:0]  spawn_y;
  logic [7:0]  kill_count;

  int n_tests = 0;
  int n_fail  = 0;
  int quiet;

  always #5 frame_clk = ~frame_clk;

  enemy_spawn_sched #(
    .NSLOT   (4),
    .NSPAWN  (5),
    .FIRE_GAP(30)
  ) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .play       (play),
    .progress   (progress),
    .kill       (kill),
    .offscreen  (offscreen),
    .fire_req   (fire_req),
    .slot_active(slot_active),
    .spawn_valid(spawn_valid),
    .spawn_slot (spawn_slot),
    .spawn_x    (spawn_x),
    .spawn_y    (spawn_y),
    .fire_gnt   (fire_gnt),
    .kill_count (kill_count),
    .level_clear(level_clear)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check_spawn(input string tag, input logic [1:0] slot, input logic [12:0] x,
                             input logic [9:0] y, input logic [3:0] act);
    check({tag, "_valid"}, 32'(spawn_valid), 32'd1);
    check({tag, "_slot"}, 32'(spawn_slot), 32'(slot));
    check({tag, "_x"}, 32'(spawn_x), 32'(x));
    check({tag, "_y"}, 32'(spawn_y), 32'(y));
    check({tag, "_active"}, 32'(slot_active), 32'(act));
  endtask

  initial begin
    Reset = 1'b1; play = 1'b0; progress = '0;
    kill = '0; offscreen = '0; fire_req = '0;
    #2;
    check("rst_active", 32'(slot_active), 32'd0);
    check("rst_valid", 32'(spawn_valid), 32'd0);
    check("rst_x", 32'(spawn_x), 32'd0);
    check("rst_gnt", 32'(fire_gnt), 32'd0);
    check("rst_kills", 32'(kill_count), 32'd0);
    check("rst_clear", 32'(level_clear), 32'd0);
    #10;
    Reset = 1'b0;

    // First spawn: 160 + 640 >= 800, lands the frame after play rises.
    play = 1'b1; progress = 12'd160;
    step(); check_spawn("sp0", 2'd0, 13'd640, 10'd159, 4'b0001);
    step(); check("sp0_pulse", 32'(spawn_valid), 32'd0);

    progress = 12'd944;  step(); check_spawn("sp1", 2'd1, 13'd640, 10'd351, 4'b0011);
    progress = 12'd1712; step(); check_spawn("sp2", 2'd2, 13'd640, 10'd255, 4'b0111);
    progress = 12'd3760; step(); check_spawn("sp3", 2'd3, 13'd30, 10'd255, 4'b1111);

    // Entry 4 is due (3760 + 640 = 4400) but every slot is busy: stall.
    step(); check("stall_a", 32'(spawn_valid), 32'd0);
    step(); check("stall_b", 32'(spawn_valid), 32'd0);
    check("stall_active", 32'(slot_active), 32'hF);

`ifdef SPAWN_FIRE_ARB_EN
    fire_req = 4'hF;
    step(); check("gnt0", 32'(fire_gnt), 32'b0001);
    quiet = 0;
    for (int n = 1; n < 30; n++) begin step(); quiet += int'(fire_gnt != '0); end
    step(); check("gnt1", 32'(fire_gnt), 32'b0010);
    for (int n = 0; n < 5; n++) begin step(); quiet += int'(fire_gnt != '0); end
    play = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      quiet += int'(fire_gnt != '0) + int'(spawn_valid) + int'(slot_active != 4'hF);
    end
    play = 1'b1;
    for (int n = 0; n < 24; n++) begin step(); quiet += int'(fire_gnt != '0); end
    step(); check("gnt2", 32'(fire_gnt), 32'b0100);
    for (int n = 1; n < 30; n++) begin step(); quiet += int'(fire_gnt != '0); end
    step(); check("gnt3", 32'(fire_gnt), 32'b1000);
    check("cooldown_quiet", 32'(quiet), 32'd0);
    fire_req = '0;
`else
    fire_req = 4'hF;
    step(); check("gnt_all", 32'(fire_gnt), 32'hF);
    fire_req = 4'b0101;
    step(); check("gnt_some", 32'(fire_gnt), 32'b0101);
    play = 1'b0;
    step(); check("freeze_gnt", 32'(fire_gnt), 32'd0);
    check("freeze_active", 32'(slot_active), 32'hF);
    fire_req = '0; play = 1'b1;
    step(); check("gnt_none", 32'(fire_gnt), 32'd0);
`endif

    // Kill slot 2: released next frame, reused (entry 4) one frame later.
    kill = 4'b0100;
    step(); kill = '0;
    check("rel2_active", 32'(slot_active), 32'b1011);
    check("rel2_valid", 32'(spawn_valid), 32'd0);
    check("rel2_kills", 32'(kill_count), 32'd1);
    step(); check_spawn("sp4", 2'd2, 13'd640, 10'd159, 4'b1111);

    // Kill and offscreen together count as a kill.
    kill = 4'b0010; offscreen = 4'b0010;
    step(); kill = '0; offscreen = '0;
    check("both_kills", 32'(kill_count), 32'd2);
    check("both_active", 32'(slot_active), 32'b1101);
    offscreen = 4'b1000;
    step(); offscreen = '0;
    check("off_kills", 32'(kill_count), 32'd2);
    check("off_active", 32'(slot_active), 32'b0101);
    kill = 4'b1000;
    step(); kill = '0;
    check("dead_kill", 32'(kill_count), 32'd2);

    // Last two enemies die; level clears the frame after the release.
    kill = 4'b0101;
    step(); kill = '0;
    check("last_active", 32'(slot_active), 32'd0);
    check("last_kills", 32'(kill_count), 32'd4);
    check("clear_early", 32'(level_clear), 32'd0);
    step(); check("clear", 32'(level_clear), 32'd1);

    #2 Reset = 1'b1;
    #1;
    check("abort_clear", 32'(level_clear), 32'd0);
    check("abort_kills", 32'(kill_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
